mul_operand_serializer: RTL and testbench
=========================================

Name: mul_operand_serializer

Overview:
- Upstream feeder and result collector for the bit-serial sequential multiplier seq_mul.
- Accepts a parallel operand pair over a valid/ready handshake.
- Holds the multiplicand steady, clears the multiplier's accumulator, then streams the multiplier operand one bit per cycle, LSB first.
- Captures the 2*WIDTH product and presents it downstream over a valid/ready handshake.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- in_a  in  WIDTH  multiplicand
- in_b  in  WIDTH  multiplier, serialized LSB first
- mul_out  out  WIDTH  registered multiplicand to seq_mul
- mul_clr  out  1  one-cycle pulse clearing seq_mul accumulator
- bit_out  out  1  current serial multiplier bit
- bit_valid  out  1  bit_out is meaningful this cycle
- prod_in  in  2*WIDTH  product from seq_mul
- out_valid  out  1  out_prod valid
- out_ready  in  1  consumer accepts out_prod
- out_prod  out  2*WIDTH  captured product

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: FSM=IDLE; mul_out=0, mul_clr=0, bit_out=0, bit_valid=0, out_valid=0, out_prod=0; internal shift register and counter=0; in_ready=1 in the first cycle after reset deasserts.
- Outputs: all registered except in_ready, which is decoded from state (in_ready = state==IDLE).
- FSM states and transitions:
  - IDLE: on in_valid&&in_ready, latch in_a->mul_out and in_b->shift register, go to CLR.
  - CLR: mul_clr=1 for exactly one cycle, go to SHIFT with counter=0.
  - SHIFT: bit_valid=1, bit_out=shreg[0]; shreg shifts right each cycle; counter increments. Leave after exactly WIDTH cycles (counter==WIDTH-1) and go to SETTLE.
  - SETTLE: one cycle for seq_mul's final add; prod_in is sampled into out_prod at the end of this cycle; go to HOLD.
  - HOLD: out_valid=1; out_prod stable; on out_ready go to IDLE.
- Latency: acceptance at edge 0 -> mul_clr high in cycle 1 -> bits in cycles 2..WIDTH+1 -> out_valid first high in cycle WIDTH+3 (11 for WIDTH=8).
- Throughput: one operation per WIDTH+4 cycles minimum; no overlap between operations.
- Handshakes:
  - out_valid holds, and out_prod is unchanged, until out_ready; out_ready while out_valid=0 is ignored.
  - in_valid outside IDLE is ignored; in_a/in_b are not sampled then.
- mul_out holds its value from acceptance until the next acceptance and is not cleared at HOLD exit.
- Reset mid-operation (any state): abort, all outputs return to reset values next cycle, no partial product is emitted.
- Simultaneous out_ready in HOLD and in_valid: the result is consumed; the new operand is accepted only in the following IDLE cycle.
- Width rule: out_prod is exactly 2*WIDTH bits, captured from prod_in with no truncation.

Optional Feature:
- Macro: MUL_OPERAND_SERIALIZER_ZERO_BYPASS_EN.
- Defined: if in_a==0 or in_b==0 at acceptance, skip CLR/SHIFT/SETTLE; out_prod=0 and out_valid=1 the cycle after acceptance; mul_clr and bit_valid stay 0.
- Undefined: all operands take the full WIDTH+3 path.

Decomposition:
- Shared package mul_pkg: state enum (IDLE, CLR, SHIFT, SETTLE, HOLD), default WIDTH constant, PROD_W = 2*WIDTH.
- Natural sub-module: mul_bit_shifter (load/shift register plus bit counter, with a last-bit flag). The FSM and handshakes stay in the top module.

Test Plan:
- Basic: bench instantiates seq_mul downstream. a=37, b=16 -> bit_out sequence 0,0,0,0,1,0,0,0 in cycles 2..9; mul_clr pulse in cycle 1; out_prod=592 (0x0250) with out_valid in cycle 11.
- Max operands: 255*255 -> out_prod=65025 (0xFE01); in_ready low for the whole operation.
- Backpressure: out_ready held low 5 cycles after out_valid -> out_prod stable, in_valid pulses ignored, in_ready=0; on release, next pair 3*5 -> 15.
- Reset mid-shift: assert reset in cycle 5 -> next cycle all outputs 0, in_ready=1; new pair 7*9 -> 63 correct.
- Back-to-back with continuous in_valid and out_ready=1: pairs (1,1), (2,128), (200,3) -> 1, 256, 600; acceptances spaced exactly WIDTH+4=12 cycles apart.
- Zero bypass, with MUL_OPERAND_SERIALIZER_ZERO_BYPASS_EN defined: 0*200 -> out_prod=0, out_valid the cycle after acceptance, no mul_clr. Without the macro: same result in cycle 11.

Source files
------------

// File: rtl/mul_operand_serializer_pkg.sv
// mul_pkg: FSM state encoding and width constants shared by the operand serializer,
// its bit shifter and the testbench.
package mul_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int PROD_W    = 2 * WIDTH_DEF;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    SETTLE,
    HOLD
  } state_e;

endpackage

// File: rtl/mul_operand_serializer_if.sv
// Operand-in / seq_mul / product-out bundle of mul_operand_serializer.
// The master modport is the serializer itself; slave is the surrounding environment.
interface mul_operand_serializer_if #(
  parameter int WIDTH = mul_pkg::WIDTH_DEF
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [WIDTH-1:0]   mul_out;
  logic               mul_clr;
  logic               bit_out;
  logic               bit_valid;
  logic [2*WIDTH-1:0] prod_in;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;

  modport master (
    input  in_valid, in_a, in_b, prod_in, out_ready,
    output in_ready, mul_out, mul_clr, bit_out, bit_valid, out_valid, out_prod
  );

  modport slave (
    output in_valid, in_a, in_b, prod_in, out_ready,
    input  in_ready, mul_out, mul_clr, bit_out, bit_valid, out_valid, out_prod
  );

endinterface

// File: rtl/mul_operand_serializer_bit_shifter.sv
// mul_bit_shifter: right-shifting multiplier register with a bit counter whose
// last_o flag marks the final serial bit.
module mul_bit_shifter
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             cnt_en_i,
  output logic             lsb_o,
  output logic             last_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = load_data_i;
      cnt_d   = '0;
    end else begin
      if (shift_i) shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      if (cnt_en_i) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lsb_o  = shreg_q[0];
  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mul_operand_serializer.sv
// Feeds seq_mul: holds the multiplicand, pulses clear, streams the multiplier LSB first,
// then captures the product. Optional macro: MUL_OPERAND_SERIALIZER_ZERO_BYPASS_EN.
module mul_operand_serializer
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  mul_operand_serializer_if.master bus
);

  state_e state_q, state_d;

  logic [WIDTH-1:0]   mul_out_q, mul_out_d;
  logic               mul_clr_q, mul_clr_d;
  logic               bit_out_q, bit_out_d;
  logic               bit_valid_q, bit_valid_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] out_prod_q, out_prod_d;

  logic accept;
  logic zero_op;
  logic shift_lsb;
  logic shift_last;

  assign accept = (state_q == IDLE) && bus.in_valid;

`ifdef MUL_OPERAND_SERIALIZER_ZERO_BYPASS_EN
  assign zero_op = (bus.in_a == '0) || (bus.in_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  mul_bit_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk         (clk),
    .reset       (reset),
    .load_i      (accept),
    .load_data_i (bus.in_b),
    .shift_i     (state_d == SHIFT),
    .cnt_en_i    (state_q == SHIFT),
    .lsb_o       (shift_lsb),
    .last_o      (shift_last)
  );

  // Registered outputs are derived from the next state so they line up with it.
  always_comb begin
    state_d     = state_q;
    mul_out_d   = mul_out_q;
    out_prod_d  = out_prod_q;
    case (state_q)
      IDLE:    if (accept) state_d = zero_op ? HOLD : CLR;
      CLR:     state_d = SHIFT;
      SHIFT:   if (shift_last) state_d = SETTLE;
      SETTLE:  state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) mul_out_d = bus.in_a;
    if (state_q == SETTLE) out_prod_d = bus.prod_in;
    if (accept && zero_op) out_prod_d = '0;

    mul_clr_d   = (state_d == CLR);
    bit_valid_d = (state_d == SHIFT);
    bit_out_d   = (state_d == SHIFT) ? shift_lsb : 1'b0;
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mul_out_q   <= '0;
      mul_clr_q   <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
    end else begin
      state_q     <= state_d;
      mul_out_q   <= mul_out_d;
      mul_clr_q   <= mul_clr_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      out_valid_q <= out_valid_d;
      out_prod_q  <= out_prod_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.mul_out   = mul_out_q;
  assign bus.mul_clr   = mul_clr_q;
  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_prod  = out_prod_q;

endmodule

// File: tb/tb_mul_operand_serializer.sv
// Directed bench for mul_operand_serializer with a behavioural seq_mul downstream.
module tb_mul_operand_serializer;
  import mul_pkg::*;

  localparam int W   = WIDTH_DEF;
  localparam int LAT = W + 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_operand_serializer_if #(.WIDTH(W)) bus ();

  mul_operand_serializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural seq_mul: shift-and-add of the multiplicand for each serial bit.
  logic [PROD_W-1:0] acc_q;
  logic [3:0]        idx_q;
  always_ff @(posedge clk) begin
    if (reset || bus.mul_clr) begin
      acc_q <= '0;
      idx_q <= '0;
    end else if (bus.bit_valid) begin
      if (bus.bit_out) acc_q <= acc_q + (PROD_W'(bus.mul_out) << idx_q);
      idx_q <= idx_q + 4'd1;
    end
  end
  assign bus.prod_in = acc_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [PROD_W-1:0] exp, input int hold, input string tag);
    int cyc, nclr, clr_cyc, nbits, first_bit, ov_cyc, rdy_bad, exp_lat;
    logic [W-1:0] bits;
    logic bypass;
    bypass = 1'b0;
`ifdef MUL_OPERAND_SERIALIZER_ZERO_BYPASS_EN
    bypass = (a == 0) || (b == 0);
`endif
    exp_lat = bypass ? 1 : LAT;
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " ready_before"}, bus.in_ready, 1);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a = ~a;
    bus.in_b = ~b;
    cyc = 0; nclr = 0; clr_cyc = -1; nbits = 0; first_bit = -1; ov_cyc = -1; rdy_bad = 0;
    bits = '0;
    while (ov_cyc < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.mul_clr) begin nclr++; clr_cyc = cyc; end
      if (bus.bit_valid) begin
        if (nbits < W) bits[nbits] = bus.bit_out;
        if (nbits == 0) first_bit = cyc;
        nbits++;
      end
      if (bus.in_ready) rdy_bad++;
      if (bus.out_valid) ov_cyc = cyc;
    end
    check({tag, " latency"}, ov_cyc, exp_lat);
    check({tag, " prod"}, bus.out_prod, exp);
    check({tag, " mul_out"}, bus.mul_out, a);
    check({tag, " clr_pulses"}, nclr, bypass ? 0 : 1);
    check({tag, " clr_cycle"}, clr_cyc, bypass ? -1 : 1);
    check({tag, " bit_count"}, nbits, bypass ? 0 : W);
    check({tag, " first_bit_cycle"}, first_bit, bypass ? -1 : 2);
    check({tag, " bits"}, bits, bypass ? 0 : b);
    check({tag, " ready_low"}, rdy_bad, 0);
    // Backpressure: result must stay put while stray operands are offered.
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 8'h11;
      bus.in_b = 8'h22;
      @(negedge clk);
      check({tag, " hold_prod"}, bus.out_prod, exp);
      check({tag, " hold_valid"}, bus.out_valid, 1);
      check({tag, " hold_ready"}, bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " consumed_valid"}, bus.out_valid, 0);
    check({tag, " consumed_ready"}, bus.in_ready, 1);
    $display("op %s: %0d * %0d -> %0d, out_valid at cycle %0d", tag, a, b, bus.out_prod, ov_cyc);
  endtask

  typedef struct {
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic [PROD_W-1:0] prod;
    int                hold;
  } vec_t;

  vec_t vecs[5];

  logic [W-1:0]      pa[3];
  logic [W-1:0]      pb[3];
  logic [PROD_W-1:0] pe[3];
  int                acc_t[3];
  int                nacc, nres;
  logic              took;

  initial begin
    vecs[0] = '{a: 8'd37,  b: 8'd16,  prod: 16'd592,   hold: 0};
    vecs[1] = '{a: 8'd255, b: 8'd255, prod: 16'd65025, hold: 5};
    vecs[2] = '{a: 8'd3,   b: 8'd5,   prod: 16'd15,    hold: 0};
    vecs[3] = '{a: 8'd0,   b: 8'd200, prod: 16'd0,     hold: 0};
    vecs[4] = '{a: 8'd128, b: 8'd2,   prod: 16'd256,   hold: 2};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst mul_out", bus.mul_out, 0);
    check("rst mul_clr", bus.mul_clr, 0);
    check("rst bit_valid", bus.bit_valid, 0);
    check("rst out_valid", bus.out_valid, 0);
    check("rst out_prod", bus.out_prod, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst in_ready", bus.in_ready, 1);

    for (int i = 0; i < 5; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].hold, $sformatf("vec%0d", i));

    // Reset in the middle of the serial phase.
    bus.in_a = 8'd99;
    bus.in_b = 8'd77;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst shifting", bus.bit_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst mul_out", bus.mul_out, 0);
    check("midrst mul_clr", bus.mul_clr, 0);
    check("midrst bit_out", bus.bit_out, 0);
    check("midrst bit_valid", bus.bit_valid, 0);
    check("midrst out_valid", bus.out_valid, 0);
    check("midrst out_prod", bus.out_prod, 0);
    check("midrst in_ready", bus.in_ready, 1);
    reset = 1'b0;
    $display("op midrst: reset asserted in cycle 5 of 99 * 77");
    run_op(8'd7, 8'd9, 16'd63, 0, "after_rst");

    // Back-to-back with in_valid and out_ready held high.
    pa = '{8'd1, 8'd2, 8'd200};
    pb = '{8'd1, 8'd128, 8'd3};
    pe = '{16'd1, 16'd256, 16'd600};
    nacc = 0;
    nres = 0;
    bus.out_ready = 1'b1;
    bus.in_a = pa[0];
    bus.in_b = pb[0];
    bus.in_valid = 1'b1;
    for (int c = 0; c < 80 && nres < 3; c++) begin
      took = bus.in_valid && bus.in_ready;
      if (took) begin
        acc_t[nacc] = c;
        nacc++;
      end
      if (bus.out_valid) begin
        check($sformatf("b2b prod%0d", nres), bus.out_prod, pe[nres]);
        $display("op b2b%0d: %0d * %0d -> %0d at cycle %0d", nres, pa[nres], pb[nres], bus.out_prod, c);
        nres++;
      end
      @(posedge clk);
      #1;
      if (took) begin
        if (nacc < 3) begin
          bus.in_a = pa[nacc];
          bus.in_b = pb[nacc];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b accepts", nacc, 3);
    check("b2b results", nres, 3);
    if (nacc == 3) begin
      check("b2b spacing01", acc_t[1] - acc_t[0], W + 4);
      check("b2b spacing12", acc_t[2] - acc_t[1], W + 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
